// File: rtl/mini_alu_pkg.sv
// Shared types and constants for the mini-ALU instruction sequencer.
// The instruction word is packed {op, x, y, z}, two bits per field.
package mini_alu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        RUN_WAIT = 2'b10,
        HALT     = 2'b11
    } state_e;

    localparam logic [1:0] OP_LDL = 2'b00;
    localparam logic [1:0] OP_LDH = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int OP_W    = 2;
    localparam int X_W     = 2;
    localparam int Y_W     = 2;
    localparam int Z_W     = 2;
    localparam int INSTR_W = OP_W + X_W + Y_W + Z_W;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic [Z_W-1:0]  z;
    } instr_t;

    function automatic instr_t to_instr(input logic [INSTR_W-1:0] word);
        instr_t r;
        r.op = word[INSTR_W-1 -: OP_W];
        r.x  = word[Y_W+Z_W +: X_W];
        r.y  = word[Z_W +: Y_W];
        r.z  = word[0 +: Z_W];
        return r;
    endfunction

endpackage

// File: rtl/mini_alu_sequencer_btn_debounce.sv
// Raw push-button conditioner: two-flop synchronizer, stability counter and
// a single-cycle pulse on each accepted press (rising edge of the clean level).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          pulse_r;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
            pulse_r  <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= '0;
            pulse_r  <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= sync2_r;
            cnt_r    <= '0;
            pulse_r  <= sync2_r;
        end else begin
            cnt_r    <= cnt_r + CW'(1);
            pulse_r  <= 1'b0;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/mini_alu_sequencer.sv
// Program store plus issue engine feeding the mini-ALU executor: buttons load,
// clear, single-step or free-run a small instruction RAM over valid/ready.
module mini_alu_sequencer
    import mini_alu_pkg::*;
#(
    parameter int PROG_DEPTH      = 16,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int RUN_DIV         = 1200000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   sw,
    input  logic                         btn_load,
    input  logic                         btn_step,
    input  logic                         btn_run,
    input  logic                         btn_clr,
    output logic [7:0]                   instr,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [$clog2(PROG_DEPTH):0]  pc,
    output logic [$clog2(PROG_DEPTH):0]  prog_len,
    output logic                         halted
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int W  = AW + 1;
    localparam int TW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [W-1:0]  DEPTH_L    = W'(PROG_DEPTH);
    localparam logic [W-1:0]  ONE_L      = {{AW{1'b0}}, 1'b1};
    localparam logic [TW-1:0] TIMER_LAST = TW'(RUN_DIV - 1);

    logic [3:0]    pulse_s;
    logic          clr_s, load_s, run_s, step_s;

    state_e        state_r, state_n;
    logic [W-1:0]  pc_r, pc_n;
    logic [W-1:0]  len_r, len_n;
    logic [7:0]    instr_r, instr_n;
    logic          instr_valid_r, valid_n;
    logic          run_flag_r, run_flag_n;
    logic [TW-1:0] timer_r, timer_n;
    logic          halted_r, halted_n;
    logic          we_s;
    logic          load_ok_s;
    instr_t        ram_r [PROG_DEPTH];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst(rst), .btn_raw(btn_load), .pulse(pulse_s[0]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .rst(rst), .btn_raw(btn_step), .pulse(pulse_s[1]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .rst(rst), .btn_raw(btn_run), .pulse(pulse_s[2]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .rst(rst), .btn_raw(btn_clr), .pulse(pulse_s[3]));

    // Simultaneous presses resolve clr > load > run > step; losers are dropped.
    assign clr_s     = pulse_s[3];
    assign load_s    = pulse_s[0] & ~pulse_s[3];
    assign run_s     = pulse_s[2] & ~pulse_s[3] & ~pulse_s[0];
    assign step_s    = pulse_s[1] & ~pulse_s[3] & ~pulse_s[0] & ~pulse_s[2];
    assign load_ok_s = load_s && (len_r < DEPTH_L);

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        len_n      = len_r;
        instr_n    = instr_r;
        valid_n    = instr_valid_r;
        run_flag_n = run_flag_r;
        timer_n    = timer_r;
        we_s       = 1'b0;
        if (clr_s) begin
            state_n    = IDLE;
            pc_n       = '0;
            len_n      = '0;
            valid_n    = 1'b0;
            run_flag_n = 1'b0;
            timer_n    = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        if (load_ok_s) begin
                            we_s  = 1'b1;
                            len_n = len_r + ONE_L;
                        end else begin
                            we_s  = 1'b0;
                        end
                    end else if (run_s || step_s) begin
                        if (pc_r < len_r) begin
                            state_n    = ISSUE;
                            valid_n    = 1'b1;
                            instr_n    = ram_r[pc_r[AW-1:0]];
                            run_flag_n = run_s;
                        end else if (len_r != '0) begin
                            state_n    = HALT;
                        end else begin
                            state_n    = IDLE;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                ISSUE: begin
                    // A run press here only cancels free-run; the pending word still goes out.
                    if (run_s) begin
                        run_flag_n = 1'b0;
                    end else begin
                        run_flag_n = run_flag_r;
                    end
                    if (instr_valid_r && instr_ready) begin
                        valid_n = 1'b0;
                        pc_n    = pc_r + ONE_L;
                        if ((pc_r + ONE_L) == len_r) begin
                            state_n    = HALT;
                            run_flag_n = 1'b0;
                        end else if (run_flag_r && !run_s) begin
                            state_n    = RUN_WAIT;
                            timer_n    = '0;
                        end else begin
                            state_n    = IDLE;
                            run_flag_n = 1'b0;
                        end
                    end else begin
                        valid_n = 1'b1;
                    end
                end
                RUN_WAIT: begin
                    if (run_s) begin
                        state_n    = IDLE;
                        timer_n    = '0;
                        run_flag_n = 1'b0;
                    end else if (timer_r == TIMER_LAST) begin
                        state_n = ISSUE;
                        timer_n = '0;
                        valid_n = 1'b1;
                        instr_n = ram_r[pc_r[AW-1:0]];
                    end else begin
                        timer_n = timer_r + TW'(1);
                    end
                end
                HALT: begin
                    if (load_s) begin
                        if (load_ok_s) begin
                            we_s  = 1'b1;
                            len_n = len_r + ONE_L;
                        end else begin
                            we_s  = 1'b0;
                        end
                    end else if (run_s || step_s) begin
                        state_n = IDLE;
                        pc_n    = '0;
                    end else begin
                        state_n = HALT;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    valid_n    = 1'b0;
                    run_flag_n = 1'b0;
                    timer_n    = '0;
                end
            endcase
        end
        halted_n = (state_n == HALT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            pc_r          <= '0;
            len_r         <= '0;
            instr_r       <= 8'h00;
            instr_valid_r <= 1'b0;
            run_flag_r    <= 1'b0;
            timer_r       <= '0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_n;
            pc_r          <= pc_n;
            len_r         <= len_n;
            instr_r       <= instr_n;
            instr_valid_r <= valid_n;
            run_flag_r    <= run_flag_n;
            timer_r       <= timer_n;
            halted_r      <= halted_n;
        end
    end

    // Program RAM: contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            ram_r[len_r[AW-1:0]] <= to_instr(sw);
        end else begin
            ram_r[len_r[AW-1:0]] <= ram_r[len_r[AW-1:0]];
        end
    end

    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign prog_len    = len_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_mini_alu_sequencer.sv
// Directed-plus-random bench for mini_alu_sequencer with an in-order
// scoreboard of the stored program and the expected issue index.
module tb_mini_alu_sequencer;

    localparam int DEPTH = 16;
    localparam int DEB   = 4;
    localparam int RDIV  = 8;
    localparam int W     = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   sw;
    logic [3:0]   btns;   // {clr, run, step, load}
    logic         instr_ready;
    logic [7:0]   instr;
    logic         instr_valid;
    logic [W-1:0] pc;
    logic [W-1:0] prog_len;
    logic         halted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] m_prog[$];
    int         m_pc   = 0;
    int         n_xfer = 0;
    int         xfer_cyc[$];
    int         cyc    = 0;

    always #5 clk = ~clk;

    mini_alu_sequencer #(
        .PROG_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB), .RUN_DIV(RDIV)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .btn_load(btns[0]), .btn_step(btns[1]), .btn_run(btns[2]), .btn_clr(btns[3]),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .prog_len(prog_len), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [3:0] m);
        btns = m;
        tick(2 * DEB);
        btns = 4'b0000;
        tick(2 * DEB);
    endtask

    task automatic load_word(input logic [7:0] w);
        sw = w;
        press(4'b0001);
        if (m_prog.size() < DEPTH) m_prog.push_back(w);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!instr_valid && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, instr_valid, 1);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every handshake must carry the next stored word in order.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (m_pc < m_prog.size()) check("xfer_instr", instr, m_prog[m_pc]);
            else check("xfer_in_range", m_pc, m_prog.size());
            n_xfer++;
            xfer_cyc.push_back(cyc);
            m_pc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nx;
        int k;
        rst = 1'b1; btns = 4'b0000; sw = 8'h00; instr_ready = 1'b0;
        tick(3);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 8'h00);
        check("rst_pc", pc, 0);
        check("rst_len", prog_len, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;
        tick(2);

        // Asynchronous reset while a word is being offered.
        load_word(8'h5A);
        btns = 4'b0010;
        wait_valid("pre_rst_valid", 20);
        check("pre_rst_instr", instr, 8'h5A);
        rst = 1'b1;
        #1;
        check("midrst_valid", instr_valid, 0);
        check("midrst_pc", pc, 0);
        check("midrst_len", prog_len, 0);
        check("midrst_halted", halted, 0);
        m_prog.delete(); m_pc = 0;
        btns = 4'b0000;
        tick(3);
        rst = 1'b0;
        tick(2);

        load_word(8'h1B);
        load_word(8'h86);
        load_word(8'hE7);
        check("load_len", prog_len, 3);
        check("load_pc", pc, 0);
        check("load_valid", instr_valid, 0);

        // Single step with a stalled executor.
        instr_ready = 1'b0;
        btns = 4'b0010;
        wait_valid("step_valid", 20);
        btns = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", instr_valid, 1);
            check("stall_instr", instr, 8'h1B);
            tick(1);
        end
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        tick(10);
        check("step_nxfer", n_xfer, 1);
        check("step_pc", pc, 1);
        check("step_pc_model", pc, m_pc);
        check("step_valid_low", instr_valid, 0);
        check("step_halted", halted, 0);

        // Free run to the end of the program.
        instr_ready = 1'b1;
        xfer_cyc.delete();
        press(4'b0100);
        k = 0;
        while (!halted && k < 60) begin
            tick(1);
            k++;
        end
        check("run_halted", halted, 1);
        check("run_nxfer", xfer_cyc.size(), 2);
        if (xfer_cyc.size() >= 2) check("run_interval", xfer_cyc[1] - xfer_cyc[0], RDIV + 1);
        check("run_pc", pc, 3);
        check("run_pc_model", pc, m_pc);

        // Step out of HALT: rewind only, nothing issued.
        nx = n_xfer;
        press(4'b0010);
        m_pc = 0;
        tick(4);
        check("restart_pc", pc, 0);
        check("restart_halted", halted, 0);
        check("restart_valid", instr_valid, 0);
        check("restart_nxfer", n_xfer, nx);

        // Short glitches on step must be rejected.
        repeat (4) begin
            btns = 4'b0010; tick(3);
            btns = 4'b0000; tick(3);
        end
        tick(20);
        check("bounce_nxfer", n_xfer, nx);
        check("bounce_valid", instr_valid, 0);
        check("bounce_pc", pc, 0);

        // Clear beats load in the same sample.
        sw = 8'hFF;
        press(4'b1001);
        m_prog.delete(); m_pc = 0;
        check("clr_len", prog_len, 0);
        check("clr_pc", pc, 0);
        check("clr_valid", instr_valid, 0);

        // Overfill with random words; the extra load must not wrap onto slot 0.
        for (int i = 0; i < DEPTH + 1; i++) load_word(8'($urandom_range(0, 255)));
        check("full_len", prog_len, DEPTH);
        nx = n_xfer;
        press(4'b0010);
        check("full_step_nxfer", n_xfer, nx + 1);
        check("full_step_pc", pc, m_pc);

        // Pause free-run from inside the inter-issue wait.
        press(4'b0100);
        nx = n_xfer;
        k = 0;
        while (n_xfer == nx && k < 30) begin
            tick(1);
            k++;
        end
        check("pause_xfer_seen", n_xfer != nx, 1);
        nx = n_xfer;
        btns = 4'b0100;
        tick(2 * DEB);
        btns = 4'b0000;
        tick(40);
        check("pause_nxfer", n_xfer, nx);
        check("pause_valid", instr_valid, 0);
        check("pause_halted", halted, 0);
        check("pause_pc", pc, m_pc);
        press(4'b0010);
        check("after_pause_nxfer", n_xfer, nx + 1);
        check("after_pause_pc", pc, m_pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
